// File: rtl/midi_msg_tx.sv
// MIDI OUT transmitter: takes one message per handshake, sizes it from the status byte,
// optionally drops a repeated channel status, and shifts it out as 8N1 frames.
module midi_msg_tx #(
  parameter int BIT_DIV        = 1600,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic       reg_clk,
  input  logic       reset_reg_N,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] msg_status,
  input  logic [7:0] msg_data1,
  input  logic [7:0] msg_data2,
  input  logic       rs_clear,
  output logic       midi_txd,
  output logic       tx_busy,
  output logic       byte_sent
);

  // state   | meaning
  // IDLE    | waiting for a message, msg_ready high
  // LOAD    | pick next byte into the shifter (1 cycle)
  // START   | start bit, txd low for BIT_DIV cycles
  // DATA    | 8 data bits, LSB first, BIT_DIV cycles each
  // STOP    | stop bit, txd high; byte_sent on its last cycle
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] BIT_RELOAD = 16'(BIT_DIV - 1);

  state_t      state, state_next;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx, last_idx, n_bytes;
  logic [7:0]  shreg, last_status, byte0, byte1, byte2;
  logic        txd_next, tick, accept, is_chan, is_sys, rs_hit;

  assign tick    = (cnt == 16'd0);
  assign accept  = msg_valid && (state == S_IDLE);
  assign is_chan = msg_status[7] && (msg_status[7:4] != 4'hF);
  assign is_sys  = (msg_status[7:3] == 5'b11110);
  // a coincident rs_clear wins over the stored status, so the status byte is sent
  assign rs_hit  = RUNNING_STATUS && is_chan && !rs_clear && (msg_status == last_status);

  always_comb begin
    n_bytes = 2'd1;
    if (msg_status[7]) begin
      case (msg_status[7:4])
        4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n_bytes = 2'd3;
        4'hC, 4'hD:                   n_bytes = 2'd2;
        default: begin
          case (msg_status)
            8'hF2:        n_bytes = 2'd3;
            8'hF1, 8'hF3: n_bytes = 2'd2;
            default:      n_bytes = 2'd1;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) state <= S_IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    msg_ready  = 1'b0;
    tx_busy    = 1'b1;
    byte_sent  = 1'b0;
    txd_next   = 1'b1;
    case (state)
      S_IDLE: begin
        msg_ready = 1'b1;
        tx_busy   = 1'b0;
        if (msg_valid) state_next = S_LOAD;
      end
      S_LOAD:  state_next = S_START;
      S_START: begin
        txd_next = 1'b0;
        if (tick) state_next = S_DATA;
      end
      S_DATA: begin
        txd_next = shreg[0];
        if (tick && bit_idx == 3'd7) state_next = S_STOP;
      end
      S_STOP: begin
        if (tick) begin
          byte_sent  = 1'b1;
          state_next = (byte_idx == last_idx) ? S_IDLE : S_LOAD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      midi_txd    <= 1'b1;
      cnt         <= 16'd0;
      bit_idx     <= 3'd0;
      byte_idx    <= 2'd0;
      last_idx    <= 2'd0;
      shreg       <= 8'd0;
      last_status <= 8'd0;
      byte0       <= 8'd0;
      byte1       <= 8'd0;
      byte2       <= 8'd0;
    end else begin
      midi_txd <= txd_next;
      if (accept) begin
        byte0    <= msg_status;
        byte1    <= {1'b0, msg_data1[6:0]};
        byte2    <= {1'b0, msg_data2[6:0]};
        byte_idx <= rs_hit ? 2'd1 : 2'd0;
        last_idx <= n_bytes - 2'd1;
        if (is_chan)       last_status <= msg_status;
        else if (is_sys)   last_status <= 8'd0;
        else if (rs_clear) last_status <= 8'd0;
      end else if (rs_clear) begin
        last_status <= 8'd0;
      end
      case (state)
        S_LOAD: begin
          shreg   <= (byte_idx == 2'd0) ? byte0 : (byte_idx == 2'd1) ? byte1 : byte2;
          cnt     <= BIT_RELOAD;
          bit_idx <= 3'd0;
        end
        S_START, S_DATA, S_STOP: begin
          cnt <= tick ? BIT_RELOAD : cnt - 16'd1;
          if (state == S_DATA && tick) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          if (state == S_STOP && tick && byte_idx != last_idx) byte_idx <= byte_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_msg_tx.sv
// Directed bench for midi_msg_tx at BIT_DIV=16: decodes the serial line back into bytes
// and checks them, byte_sent pulses, start latency and message duration.
module tb_midi_msg_tx;
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid1, valid0, rs_clear;
  logic [7:0] st, d1, d2;
  logic       ready1, txd1, busy1, sent1;
  logic       ready0, txd0, busy0, sent0;

  int n_total = 0;
  int n_pass  = 0;
  int bs1 = 0;
  int bs0 = 0;
  logic [8:0] rxq[$];

  always #5 clk = ~clk;

  midi_msg_tx #(.BIT_DIV(BD), .RUNNING_STATUS(1'b1)) dut (
    .reg_clk(clk), .reset_reg_N(rst_n), .msg_valid(valid1), .msg_ready(ready1),
    .msg_status(st), .msg_data1(d1), .msg_data2(d2), .rs_clear(rs_clear),
    .midi_txd(txd1), .tx_busy(busy1), .byte_sent(sent1));

  midi_msg_tx #(.BIT_DIV(BD), .RUNNING_STATUS(1'b0)) dut_nors (
    .reg_clk(clk), .reset_reg_N(rst_n), .msg_valid(valid0), .msg_ready(ready0),
    .msg_status(st), .msg_data1(d1), .msg_data2(d2), .rs_clear(rs_clear),
    .midi_txd(txd0), .tx_busy(busy0), .byte_sent(sent0));

  always @(negedge clk) begin
    if (sent1 === 1'b1) bs1++;
    if (sent0 === 1'b1) bs0++;
  end

  // UART decoder: sample mid-bit, push {frame_ok, byte}
  initial begin
    logic       prev;
    logic       ok;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && prev === 1'b1 && txd1 === 1'b0) begin
        ok = 1'b1;
        b  = 8'h00;
        repeat (BD / 2) @(negedge clk);
        if (txd1 !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = txd1;
        end
        repeat (BD) @(negedge clk);
        if (txd1 !== 1'b1) ok = 1'b0;
        rxq.push_back({ok, b});
      end
      prev = txd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Handshake one message; lat = cycles from accept edge to first txd low,
  // dur = cycles from accept edge until msg_ready is back (-1 if the bound expires).
  task automatic send(input bit to_nors, input logic [7:0] s, input logic [7:0] a,
                      input logic [7:0] c, input bit clr, output int lat, output int dur);
    int k;
    k = 0;
    @(negedge clk);
    while (((to_nors ? ready0 : ready1) !== 1'b1) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    st = s; d1 = a; d2 = c; rs_clear = clr;
    if (to_nors) valid0 = 1'b1; else valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid0 = 1'b0; valid1 = 1'b0; rs_clear = 1'b0;
    st = 8'hA5; d1 = 8'h5A; d2 = 8'hC3;
    lat = -1;
    dur = -1;
    for (int n = 1; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && (to_nors ? txd0 : txd1) === 1'b0) lat = n;
      if ((to_nors ? ready0 : ready1) === 1'b1) begin
        dur = n;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_bytes(input string tag, input int n, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] e;
    logic [8:0] got;
    chk({tag, " count"}, rxq.size(), n);
    for (int i = 0; i < n; i++) begin
      e   = (i == 0) ? e0 : (i == 1) ? e1 : e2;
      got = (i < rxq.size()) ? rxq[i] : 9'h000;
      chk($sformatf("%s byte%0d", tag, i), {23'd0, got}, {23'd0, 1'b1, e});
    end
    rxq.delete();
  endtask

  task automatic msg(input string tag, input logic [7:0] s, input logic [7:0] a,
                     input logic [7:0] c, input bit clr, input int n, input logic [7:0] e0,
                     input logic [7:0] e1, input logic [7:0] e2);
    int lat, dur;
    bs1 = 0;
    send(1'b0, s, a, c, clr, lat, dur);
    chk_bytes(tag, n, e0, e1, e2);
    chk({tag, " pulses"}, bs1, n);
    chk({tag, " duration"}, dur, n * (10 * BD + 1));
  endtask

  initial begin
    int lat, dur;
    rst_n = 1'b0; valid1 = 1'b0; valid0 = 1'b0; rs_clear = 1'b0;
    st = 8'h00; d1 = 8'h00; d2 = 8'h00;
    #23;
    chk("rst txd", txd1, 1);
    chk("rst ready", ready1, 1);
    chk("rst busy", busy1, 0);
    chk("rst byte_sent", sent1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: full note-on, latency and timing
    bs1 = 0;
    send(1'b0, 8'h90, 8'h3C, 8'h64, 1'b0, lat, dur);
    chk("t1 latency", lat, 2);
    chk("t1 duration", dur, 483);
    chk("t1 pulses", bs1, 3);
    chk_bytes("t1", 3, 8'h90, 8'h3C, 8'h64);

    // 2: running status drops the repeated 90
    msg("t2 rs", 8'h90, 8'h3C, 8'h00, 1'b0, 2, 8'h3C, 8'h00, 8'h00);
    bs0 = 0;
    send(1'b1, 8'h90, 8'h3C, 8'h64, 1'b0, lat, dur);
    bs0 = 0;
    send(1'b1, 8'h90, 8'h3C, 8'h00, 1'b0, lat, dur);
    chk("t2 nors pulses", bs0, 3);
    chk("t2 nors duration", dur, 483);
    rxq.delete();

    // 3: real-time byte keeps running status
    msg("t3 a", 8'hC5, 8'h07, 8'h00, 1'b0, 2, 8'hC5, 8'h07, 8'h00);
    msg("t3 rt", 8'hF8, 8'h00, 8'h00, 1'b0, 1, 8'hF8, 8'h00, 8'h00);
    msg("t3 b", 8'hC5, 8'h08, 8'h00, 1'b0, 1, 8'h08, 8'h00, 8'h00);

    // 4: sysex start cancels running status; rs_clear at accept forces status
    msg("t4 a", 8'hC5, 8'h07, 8'h00, 1'b0, 1, 8'h07, 8'h00, 8'h00);
    msg("t4 f0", 8'hF0, 8'h00, 8'h00, 1'b0, 1, 8'hF0, 8'h00, 8'h00);
    msg("t4 b", 8'hC5, 8'h09, 8'h00, 1'b0, 2, 8'hC5, 8'h09, 8'h00);
    msg("t4 c", 8'h90, 8'h3C, 8'h64, 1'b0, 3, 8'h90, 8'h3C, 8'h64);
    msg("t4 clr", 8'h90, 8'h3C, 8'h64, 1'b1, 3, 8'h90, 8'h3C, 8'h64);

    // 5: data bit7 masked; raw byte leaves running status alone
    msg("t5 mask", 8'h90, 8'hBC, 8'hFF, 1'b0, 2, 8'h3C, 8'h7F, 8'h00);
    msg("t5 raw", 8'h42, 8'h11, 8'h22, 1'b0, 1, 8'h42, 8'h00, 8'h00);
    msg("t5 keep", 8'h90, 8'h11, 8'h22, 1'b0, 2, 8'h11, 8'h22, 8'h00);
    msg("t5 f3", 8'hF3, 8'h85, 8'h00, 1'b0, 2, 8'hF3, 8'h05, 8'h00);

    // 6: reset during bit 3 of the second byte
    @(negedge clk);
    st = 8'h90; d1 = 8'h3C; d2 = 8'h64; valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    repeat (230) @(posedge clk);
    #2;
    chk("t6 busy before", busy1, 1);
    rst_n = 1'b0;
    #1;
    chk("t6 txd", txd1, 1);
    chk("t6 ready", ready1, 1);
    chk("t6 busy", busy1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    rxq.delete();
    msg("t6 after", 8'h90, 8'h3C, 8'h64, 1'b0, 3, 8'h90, 8'h3C, 8'h64);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
